// File: rtl/router_fifo.sv
// router_fifo -- output-port packet FIFO of the 1x3 router.
//
// Stores DEPTH entries of WIDTH+1 bits. Bit WIDTH of each entry is the packet
// header marker captured from lfd_state. An internal packet counter follows
// the packet being drained, so data_out holds its value between reads while
// a packet is still in flight and clears to zero once the packet is done.
//
// Ports:
//   clock       system clock, rising edge
//   resetn      synchronous active-low reset
//   soft_reset  synchronous flush (destination timeout)
//   write_enb   write request
//   read_enb    read request
//   lfd_state   marks the byte being written as a packet header
//   data_in     byte to store
//   full        FIFO holds DEPTH entries
//   empty       FIFO holds no entries
//   data_out    registered read data (valid one clock after the read edge)
//   err         (only with ROUTER_FIFO_ERR_EN) sticky overflow/underflow flag
//
// Optional feature macro: ROUTER_FIFO_ERR_EN adds the err output.
module router_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic             err
`endif
);

  logic [WIDTH:0]  mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [6:0]      pkt_count;
  logic [WIDTH:0]  rd_entry;
  logic            do_wr;
  logic            do_rd;
  logic            flush;

  // Flags come straight from the pointers; the extra MSB separates
  // the full and empty cases when the low address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Both decisions use start-of-cycle flags: no bypass from write to read.
  assign do_wr    = write_enb && !full;
  assign do_rd    = read_enb && !empty;
  assign flush    = !resetn || soft_reset;
  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      pkt_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        data_out <= rd_entry[WIDTH-1:0];
        rd_ptr   <= rd_ptr + 1'b1;
        // Header byte: length field plus the trailing parity byte.
        if (rd_entry[WIDTH]) begin
          pkt_count <= {1'b0, rd_entry[7:2]} + 7'd1;
        end else if (pkt_count != '0) begin
          pkt_count <= pkt_count - 7'd1;
        end
      end else if (pkt_count == '0) begin
        data_out <= '0;
      end
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  always_ff @(posedge clock) begin
    if (flush) begin
      err <= 1'b0;
    end else if ((write_enb && full) || (read_enb && empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo -- self-checking bench for router_fifo.
// Table-driven header-packet vectors, hand-written corner sequences, and
// randomized traffic compared against a queue-based reference model.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic [7:0] data_out;
`ifdef ROUTER_FIFO_ERR_EN
  logic       err;
`endif

  router_fifo #(.DEPTH(16), .WIDTH(8), .ADDR_W(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out)
`ifdef ROUTER_FIFO_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {marker, byte}, plus read-side state.
  logic [8:0] q [$];
  logic [7:0] m_dout;
  logic [6:0] m_pkt;
  bit         m_err;

  typedef struct {
    bit         we;
    bit         re;
    bit         lfd;
    logic [7:0] din;
    bit         e_full;
    bit         e_empty;
    logic [7:0] e_dout;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, then update the model with the same request.
  task automatic cycle(input bit rst, input bit sr, input bit we, input bit re,
                       input bit lfd, input logic [7:0] din);
    bit         f;
    bit         e;
    logic [8:0] ent;
    resetn     = !rst;
    soft_reset = sr;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    f = (q.size() == 16);
    e = (q.size() == 0);
    @(posedge clock);
    #1;
    if (rst || sr) begin
      q.delete();
      m_dout = '0;
      m_pkt  = '0;
      m_err  = 1'b0;
    end else begin
      if (re && !e) begin
        ent    = q.pop_front();
        m_dout = ent[7:0];
        if (ent[8]) m_pkt = 7'(ent[7:2]) + 7'd1;
        else if (m_pkt != 0) m_pkt = m_pkt - 7'd1;
      end else if (m_pkt == 0) begin
        m_dout = '0;
      end
      if (we && !f) q.push_back({lfd, din});
      if ((we && f) || (re && e)) m_err = 1'b1;
    end
  endtask

  task automatic chk_err(input string name, input bit exp);
`ifdef ROUTER_FIFO_ERR_EN
    chk(name, err, exp);
`else
    if (exp) begin end
`endif
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    resetn = 0; soft_reset = 0; write_enb = 0; read_enb = 0;
    lfd_state = 0; data_in = 0;

    // Header 0x14 -> length 5, plus 5 payload and 1 parity.
    tbl[0]  = '{1, 0, 1, 8'h14, 0, 0, 8'h00};
    tbl[1]  = '{1, 0, 0, 8'h01, 0, 0, 8'h00};
    tbl[2]  = '{1, 0, 0, 8'h02, 0, 0, 8'h00};
    tbl[3]  = '{1, 0, 0, 8'h03, 0, 0, 8'h00};
    tbl[4]  = '{1, 0, 0, 8'h04, 0, 0, 8'h00};
    tbl[5]  = '{1, 0, 0, 8'h05, 0, 0, 8'h00};
    tbl[6]  = '{1, 0, 0, 8'h55, 0, 0, 8'h00};
    tbl[7]  = '{0, 1, 0, 8'h00, 0, 0, 8'h14};
    tbl[8]  = '{0, 1, 0, 8'h00, 0, 0, 8'h01};
    tbl[9]  = '{0, 0, 0, 8'h00, 0, 0, 8'h01};  // idle mid-packet: hold
    tbl[10] = '{0, 1, 0, 8'h00, 0, 0, 8'h02};
    tbl[11] = '{0, 1, 0, 8'h00, 0, 0, 8'h03};
    tbl[12] = '{0, 1, 0, 8'h00, 0, 0, 8'h04};
    tbl[13] = '{0, 1, 0, 8'h00, 0, 0, 8'h05};
    tbl[14] = '{0, 1, 0, 8'h00, 0, 1, 8'h55};

    // Reset then idle.
    do_reset();
    cycle(0, 0, 0, 0, 0, 8'h00);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 8'h00);
    chk_err("rst_err", 0);

    // Header packet from the table.
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, tbl[i].we, tbl[i].re, tbl[i].lfd, tbl[i].din);
      chk($sformatf("pkt_full[%0d]", i), full, tbl[i].e_full);
      chk($sformatf("pkt_empty[%0d]", i), empty, tbl[i].e_empty);
      chk($sformatf("pkt_dout[%0d]", i), data_out, tbl[i].e_dout);
    end
    cycle(0, 0, 0, 0, 0, 8'h00);
    chk("pkt_dout_clear", data_out, 8'h00);

    // Fill to 16, overflow write dropped, drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, 0, 0, 8'(i * 3 + 1));
      chk($sformatf("fill_full[%0d]", i), full, (i == 15) ? 1 : 0);
    end
    chk_err("fill_err_clean", 0);
    cycle(0, 0, 1, 0, 0, 8'hEE);
    chk("ovf_full", full, 1);
    chk_err("ovf_err", 1);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 1, 0, 8'h00);
      chk($sformatf("drain_dout[%0d]", i), data_out, 8'(i * 3 + 1));
    end
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);

    // Full with simultaneous read and write: read proceeds, write dropped.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 0, 8'(8'h40 + i));
    cycle(0, 0, 1, 1, 0, 8'h77);
    chk("fullrw_dout", data_out, 8'h40);
    chk("fullrw_full", full, 0);
    chk_err("fullrw_err", 1);
    cycle(0, 0, 1, 0, 0, 8'h78);
    chk("fullrw_occ15", full, 1);

    // Empty with simultaneous read and write: no bypass.
    do_reset();
    cycle(0, 0, 1, 1, 0, 8'hA5);
    chk("emptyrw_dout", data_out, 8'h00);
    chk("emptyrw_empty", empty, 0);
    chk_err("emptyrw_err", 1);
    cycle(0, 0, 0, 1, 0, 8'h00);
    chk("emptyrw_read", data_out, 8'hA5);
    chk("emptyrw_empty2", empty, 1);

    // Soft reset with a concurrent write.
    do_reset();
    cycle(0, 0, 0, 1, 0, 8'h00);  // underflow sets err
    cycle(0, 0, 1, 0, 1, 8'h20);
    for (int i = 1; i < 10; i++) cycle(0, 0, 1, 0, 0, 8'(i));
    cycle(0, 0, 0, 1, 0, 8'h00);
    chk("sr_pre_dout", data_out, 8'h20);
    chk_err("sr_pre_err", 1);
    cycle(0, 1, 1, 0, 0, 8'h99);
    chk("sr_empty", empty, 1);
    chk("sr_full", full, 0);
    chk("sr_dout", data_out, 8'h00);
    chk_err("sr_err", 0);
    cycle(0, 0, 0, 0, 0, 8'h00);
    chk("sr_write_dropped", empty, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned ph;
      int unsigned wp;
      int unsigned rp;
      bit rst;
      bit sr;
      ph  = (i / 200) % 3;
      wp  = (ph == 0) ? 30 : (ph == 1) ? 60 : 90;
      rp  = (ph == 0) ? 85 : (ph == 1) ? 55 : 25;
      rst = ($urandom_range(0, 699) == 0);
      sr  = ($urandom_range(0, 99) == 0);
      cycle(rst, sr, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
            $urandom_range(0, 7) == 0, 8'($urandom));
      chk("rnd_full", full, (q.size() == 16) ? 1 : 0);
      chk("rnd_empty", empty, (q.size() == 0) ? 1 : 0);
      chk("rnd_dout", data_out, m_dout);
      chk_err("rnd_err", m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
